// File: rtl/instruction_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// instruction_sequencer_pkg
//   Shared RV32I definitions: opcode constants used by the control unit,
//   load/store type encodings, sequencer state encodings and trap causes.
//   Also holds the small opcode classification helpers used by the sequencer.
// ----------------------------------------------------------------------------
package instruction_sequencer_pkg;

   // RV32I base opcodes
   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Load/store type selector, LS_SEL_WIDTH+1 bits wide
   localparam int unsigned LS_SEL_WIDTH = 3;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_NONE         = 4'd0;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_BYTE    = 4'd1;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_HALF    = 4'd2;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_WORD    = 4'd3;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_BYTE_U  = 4'd4;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_HALF_U  = 4'd5;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_BYTE   = 4'd6;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_HALF   = 4'd7;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_WORD   = 4'd8;

   // Sequencer state encodings (visible on o_State for debug)
   localparam int unsigned SEQ_STATE_WIDTH = 3;
   typedef enum logic [SEQ_STATE_WIDTH-1:0] {
      SEQ_STATE_IDLE      = 3'd0,
      SEQ_STATE_FETCH     = 3'd1,
      SEQ_STATE_DECODE    = 3'd2,
      SEQ_STATE_EXECUTE   = 3'd3,
      SEQ_STATE_MEMORY    = 3'd4,
      SEQ_STATE_WRITEBACK = 3'd5,
      SEQ_STATE_HALTED    = 3'd6,
      SEQ_STATE_TRAP      = 3'd7
   } seq_state_e;

   typedef enum logic [1:0] {
      TRAP_CAUSE_NONE    = 2'b00,
      TRAP_CAUSE_ILLEGAL = 2'b01,
      TRAP_CAUSE_TIMEOUT = 2'b10
   } trap_cause_e;

   function automatic logic is_mem_opcode(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic logic is_legal_opcode(input logic [6:0] op);
      logic legal;
      case (op)
         OP_R_TYPE, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
         default:                          legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/instruction_sequencer_timeout.sv
// ----------------------------------------------------------------------------
// access_timeout_counter
//   Counts wait cycles of a memory access and flags expiry.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   clear_i   : hold counter at zero (not in a waiting state)
//   enable_i  : waiting and ready still low this cycle
//   expired_o : this cycle is the last permitted wait cycle with ready low
//   TIMEOUT_CYCLES = 0 disables expiry entirely.
// ----------------------------------------------------------------------------
module access_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned COUNTER_WIDTH  = 32
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic                     ENABLED = (TIMEOUT_CYCLES != 0);
   localparam logic [COUNTER_WIDTH-1:0] LIMIT   = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [COUNTER_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i)       count_d = '0;
      else if (enable_i) count_d = count_q + COUNTER_WIDTH'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   // enable_i already excludes ready, so a ready on the limit cycle wins
   assign expired_o = ENABLED && enable_i && (count_q == LIMIT);

endmodule

// File: rtl/instruction_sequencer.sv
// ----------------------------------------------------------------------------
// instruction_sequencer
//   Multi-cycle RV32I sequencer: IDLE -> FETCH -> DECODE -> EXECUTE ->
//   [MEMORY] -> WRITEBACK, plus HALTED (debug) and TRAP (reset-only exit).
//   Inputs : clock/reset, latched opcode, load/store type, ungated register
//            and memory write enables, instruction/data memory ready, halt.
//   Outputs: fetch/IR-load/data requests, gated register and PC writes,
//            retire pulse and counter, halted/trap status, state for debug.
//   Outputs are decoded from the registered state and handshake inputs.
// ----------------------------------------------------------------------------
module instruction_sequencer
   import instruction_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned COUNTER_WIDTH  = 32
) (
   input  logic                     i_Clock,
   input  logic                     i_Reset_N,
   input  logic [6:0]               i_Op_Code,
   input  logic [LS_SEL_WIDTH:0]    i_Load_Store_Type,
   input  logic                     i_Reg_Write_Enable,
   input  logic                     i_Mem_Write_Enable,
   input  logic                     i_Instr_Mem_Ready,
   input  logic                     i_Data_Mem_Ready,
   input  logic                     i_Halt_Request,
   output logic                     o_Instr_Mem_Req,
   output logic                     o_Ir_Load,
   output logic                     o_Data_Mem_Req,
   output logic                     o_Data_Mem_Write,
   output logic                     o_Reg_Write_Enable,
   output logic                     o_Pc_Write_Enable,
   output logic                     o_Retire,
   output logic [COUNTER_WIDTH-1:0] o_Instret,
   output logic                     o_Halted,
   output logic                     o_Trap,
   output logic [1:0]               o_Trap_Cause,
   output logic [2:0]               o_State
);

   seq_state_e               state_q, state_d;
   trap_cause_e              trap_cause_q, trap_cause_d;
   logic [COUNTER_WIDTH-1:0] instret_q, instret_d;

   logic waiting, access_ready, timeout_expired;

   // One counter serves both FETCH and MEMORY; it is held clear elsewhere,
   // so it always starts from zero on entry to either waiting state.
   assign waiting      = (state_q == SEQ_STATE_FETCH) || (state_q == SEQ_STATE_MEMORY);
   assign access_ready = (state_q == SEQ_STATE_FETCH) ? i_Instr_Mem_Ready : i_Data_Mem_Ready;

   access_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .COUNTER_WIDTH  (COUNTER_WIDTH)
   ) u_timeout (
      .clk_i     (i_Clock),
      .rst_ni    (i_Reset_N),
      .clear_i   (!waiting),
      .enable_i  (waiting && !access_ready),
      .expired_o (timeout_expired)
   );

   always_comb begin
      state_d      = state_q;
      trap_cause_d = trap_cause_q;
      instret_d    = instret_q;
      case (state_q)
         SEQ_STATE_IDLE: state_d = SEQ_STATE_FETCH;
         SEQ_STATE_FETCH: begin
            if (i_Instr_Mem_Ready) begin
               state_d = SEQ_STATE_DECODE;
            end else if (timeout_expired) begin
               state_d      = SEQ_STATE_TRAP;
               trap_cause_d = TRAP_CAUSE_TIMEOUT;
            end
         end
         SEQ_STATE_DECODE: begin
            if (!is_legal_opcode(i_Op_Code) ||
                (is_mem_opcode(i_Op_Code) && (i_Load_Store_Type == LS_TYPE_NONE))) begin
               state_d      = SEQ_STATE_TRAP;
               trap_cause_d = TRAP_CAUSE_ILLEGAL;
            end else begin
               state_d = SEQ_STATE_EXECUTE;
            end
         end
         SEQ_STATE_EXECUTE:
            state_d = is_mem_opcode(i_Op_Code) ? SEQ_STATE_MEMORY : SEQ_STATE_WRITEBACK;
         SEQ_STATE_MEMORY: begin
            if (i_Data_Mem_Ready) begin
               state_d = SEQ_STATE_WRITEBACK;
            end else if (timeout_expired) begin
               state_d      = SEQ_STATE_TRAP;
               trap_cause_d = TRAP_CAUSE_TIMEOUT;
            end
         end
         SEQ_STATE_WRITEBACK: begin
            instret_d = instret_q + COUNTER_WIDTH'(1);
            state_d   = i_Halt_Request ? SEQ_STATE_HALTED : SEQ_STATE_FETCH;
         end
         SEQ_STATE_HALTED: if (!i_Halt_Request) state_d = SEQ_STATE_FETCH;
         SEQ_STATE_TRAP:   state_d = SEQ_STATE_TRAP;
         default:          state_d = SEQ_STATE_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         state_q      <= SEQ_STATE_IDLE;
         trap_cause_q <= TRAP_CAUSE_NONE;
         instret_q    <= '0;
      end else begin
         state_q      <= state_d;
         trap_cause_q <= trap_cause_d;
         instret_q    <= instret_d;
      end
   end

   always_comb begin
      o_Instr_Mem_Req    = 1'b0;
      o_Ir_Load          = 1'b0;
      o_Data_Mem_Req     = 1'b0;
      o_Data_Mem_Write   = 1'b0;
      o_Reg_Write_Enable = 1'b0;
      o_Pc_Write_Enable  = 1'b0;
      o_Retire           = 1'b0;
      o_Halted           = 1'b0;
      o_Trap             = 1'b0;
      case (state_q)
         SEQ_STATE_FETCH: begin
            o_Instr_Mem_Req = 1'b1;
            o_Ir_Load       = i_Instr_Mem_Ready;
         end
         SEQ_STATE_MEMORY: begin
            o_Data_Mem_Req   = 1'b1;
            o_Data_Mem_Write = i_Mem_Write_Enable;
         end
         SEQ_STATE_WRITEBACK: begin
            o_Reg_Write_Enable = i_Reg_Write_Enable;
            o_Pc_Write_Enable  = 1'b1;
            o_Retire           = 1'b1;
         end
         SEQ_STATE_HALTED: o_Halted = 1'b1;
         SEQ_STATE_TRAP:   o_Trap   = 1'b1;
         default: ;
      endcase
   end

   assign o_Instret    = instret_q;
   assign o_Trap_Cause = trap_cause_q;
   assign o_State      = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// ----------------------------------------------------------------------------
// tb_instruction_sequencer
//   Directed bench. Retire events are checked by a monitor against a queue
//   of expected retirements; state/handshake sequencing is checked inline.
// ----------------------------------------------------------------------------
module tb_instruction_sequencer;
   import instruction_sequencer_pkg::*;

   localparam int unsigned TO = 4;
   localparam int unsigned CW = 4;

   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                          S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_TRAP = 3'd7;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [6:0]            op;
   logic [LS_SEL_WIDTH:0] ls;
   logic                  rwe, mwe, imr, dmr, halt;
   logic                  o_Instr_Mem_Req, o_Ir_Load, o_Data_Mem_Req, o_Data_Mem_Write;
   logic                  o_Reg_Write_Enable, o_Pc_Write_Enable, o_Retire;
   logic [CW-1:0]         o_Instret;
   logic                  o_Halted, o_Trap;
   logic [1:0]            o_Trap_Cause;
   logic [2:0]            o_State;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic          reg_we;
      logic [CW-1:0] instret;
   } retire_t;

   retire_t exp_q[$];
   retire_t mon_e;

   always #5 clk = ~clk;

   instruction_sequencer #(
      .TIMEOUT_CYCLES (TO),
      .COUNTER_WIDTH  (CW)
   ) dut (
      .i_Clock            (clk),
      .i_Reset_N          (rst_n),
      .i_Op_Code          (op),
      .i_Load_Store_Type  (ls),
      .i_Reg_Write_Enable (rwe),
      .i_Mem_Write_Enable (mwe),
      .i_Instr_Mem_Ready  (imr),
      .i_Data_Mem_Ready   (dmr),
      .i_Halt_Request     (halt),
      .o_Instr_Mem_Req    (o_Instr_Mem_Req),
      .o_Ir_Load          (o_Ir_Load),
      .o_Data_Mem_Req     (o_Data_Mem_Req),
      .o_Data_Mem_Write   (o_Data_Mem_Write),
      .o_Reg_Write_Enable (o_Reg_Write_Enable),
      .o_Pc_Write_Enable  (o_Pc_Write_Enable),
      .o_Retire           (o_Retire),
      .o_Instret          (o_Instret),
      .o_Halted           (o_Halted),
      .o_Trap             (o_Trap),
      .o_Trap_Cause       (o_Trap_Cause),
      .o_State            (o_State)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic we, input int unsigned n);
      retire_t e;
      e.reg_we  = we;
      e.instret = n[CW-1:0];
      exp_q.push_back(e);
   endtask

   task automatic expect_state(input string name, input logic [2:0] st);
      @(negedge clk);
      #1;
      chk(name, 32'(o_State), 32'(st));
   endtask

   task automatic wait_state(input string name, input logic [2:0] st, input int unsigned budget);
      logic seen;
      seen = 1'b0;
      for (int unsigned i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         #1;
         if (o_State == st) seen = 1'b1;
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   // Monitor: samples late in the cycle, after stimulus has settled
   always @(negedge clk) begin
      #3;
      if (o_Reg_Write_Enable || o_Pc_Write_Enable)
         chk("write_outside_wb", 32'(o_State), 32'(S_WB));
      if (o_Retire) begin
         if (exp_q.size() == 0) begin
            chk("retire_unexpected", 32'(o_Retire), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("retire_rf_we",   32'(o_Reg_Write_Enable), 32'(mon_e.reg_we));
            chk("retire_pc_we",   32'(o_Pc_Write_Enable),  32'd1);
            chk("retire_instret", 32'(o_Instret),          32'(mon_e.instret));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; op = OP_R_TYPE; ls = LS_TYPE_NONE;
      rwe = 1'b1; mwe = 1'b0; imr = 1'b1; dmr = 1'b1; halt = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_outputs", 32'({o_Instr_Mem_Req, o_Ir_Load, o_Data_Mem_Req, o_Data_Mem_Write,
                                o_Reg_Write_Enable, o_Pc_Write_Enable, o_Retire, o_Halted,
                                o_Trap, o_Trap_Cause, o_State}), 32'd0);
      chk("reset_instret", 32'(o_Instret), 32'd0);
      halt  = 1'b0;
      rst_n = 1'b1;

      // T1: R-type, zero-wait
      push_exp(1'b1, 0);
      expect_state("t1_fetch", S_FETCH);
      chk("t1_imem_req", 32'(o_Instr_Mem_Req), 32'd1);
      chk("t1_ir_load",  32'(o_Ir_Load),       32'd1);
      expect_state("t1_decode",    S_DECODE);
      expect_state("t1_execute",   S_EXEC);
      expect_state("t1_writeback", S_WB);
      op = OP_LOAD; ls = LS_TYPE_LOAD_WORD; dmr = 1'b0;
      push_exp(1'b1, 1);
      expect_state("t1_next_fetch", S_FETCH);
      chk("t1_instret", 32'(o_Instret), 32'd1);

      // T2: load, data ready on the 4th MEMORY cycle (also the timeout limit cycle)
      expect_state("t2_decode",  S_DECODE);
      expect_state("t2_execute", S_EXEC);
      for (int i = 0; i < 4; i++) begin
         expect_state("t2_memory", S_MEM);
         chk("t2_dmem_req",   32'(o_Data_Mem_Req),   32'd1);
         chk("t2_dmem_write", 32'(o_Data_Mem_Write), 32'd0);
         if (i == 3) dmr = 1'b1;
      end
      expect_state("t2_writeback", S_WB);
      op = OP_STORE; ls = LS_TYPE_STORE_WORD; mwe = 1'b1;
      push_exp(1'b0, 2);
      expect_state("t2_next_fetch", S_FETCH);
      chk("t2_instret", 32'(o_Instret), 32'd2);
      rwe = 1'b0;

      // T3: store, register write must stay gated off
      expect_state("t3_decode",  S_DECODE);
      expect_state("t3_execute", S_EXEC);
      expect_state("t3_memory",  S_MEM);
      chk("t3_dmem_req",   32'(o_Data_Mem_Req),   32'd1);
      chk("t3_dmem_write", 32'(o_Data_Mem_Write), 32'd1);
      expect_state("t3_writeback", S_WB);
      chk("t3_rf_we", 32'(o_Reg_Write_Enable), 32'd0);
      op = OP_I_ALU; ls = LS_TYPE_NONE; mwe = 1'b0;
      push_exp(1'b1, 3);
      expect_state("t3_next_fetch", S_FETCH);
      chk("t3_instret", 32'(o_Instret), 32'd3);
      rwe = 1'b1;

      // T4: halt raised during EXECUTE; instruction completes first
      expect_state("t4_decode",  S_DECODE);
      expect_state("t4_execute", S_EXEC);
      halt = 1'b1;
      expect_state("t4_writeback", S_WB);
      expect_state("t4_halted", S_HALT);
      chk("t4_halted_flag", 32'(o_Halted), 32'd1);
      chk("t4_no_req", 32'({o_Instr_Mem_Req, o_Data_Mem_Req}), 32'd0);
      expect_state("t4_halt_hold", S_HALT);
      halt = 1'b0;
      expect_state("t4_resume", S_FETCH);
      chk("t4_instret", 32'(o_Instret), 32'd4);

      // Retire counter wrap: 12 more retirements take 4 -> 16 == 0 mod 2^CW
      for (int i = 0; i < 12; i++) begin
         push_exp(1'b1, 4 + i);
         wait_state("wrap_wb", S_WB, 8);
      end
      op = 7'h7F;
      expect_state("wrap_fetch", S_FETCH);
      chk("wrap_instret", 32'(o_Instret), 32'd0);

      // T5: illegal opcode traps and stays trapped
      expect_state("t5_decode", S_DECODE);
      expect_state("t5_trap",   S_TRAP);
      chk("t5_cause", 32'(o_Trap_Cause), 32'd1);
      mwe = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         halt = ((i % 10) < 3);
         #1;
         chk("t5_trap_hold", 32'({o_Trap, o_Trap_Cause, o_State, o_Halted, o_Instr_Mem_Req,
                                  o_Data_Mem_Req, o_Data_Mem_Write}),
             32'({1'b1, 2'b01, S_TRAP, 1'b0, 1'b0, 1'b0, 1'b0}));
      end
      halt = 1'b0;

      // T6: fetch timeout with instruction ready never arriving
      rst_n = 1'b0; imr = 1'b0; op = OP_R_TYPE; mwe = 1'b0;
      #1;
      chk("t6_reset_clears_trap", 32'({o_Trap, o_Trap_Cause, o_State}), 32'd0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_state("t6_wait", S_FETCH);
         chk("t6_imem_req", 32'(o_Instr_Mem_Req), 32'd1);
         chk("t6_ir_load",  32'(o_Ir_Load),       32'd0);
      end
      expect_state("t6_trap", S_TRAP);
      chk("t6_cause", 32'(o_Trap_Cause), 32'd2);

      // T7: ready on exactly the 4th wait cycle, then reset mid-MEMORY
      rst_n = 1'b0; op = OP_LOAD; ls = LS_TYPE_LOAD_BYTE; dmr = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_state("t7_wait", S_FETCH);
         if (i == 3) begin
            imr = 1'b1;
            #1;
            chk("t7_ir_load", 32'(o_Ir_Load), 32'd1);
         end
      end
      expect_state("t7_decode",  S_DECODE);
      expect_state("t7_execute", S_EXEC);
      expect_state("t7_memory",  S_MEM);
      chk("t7_dmem_req", 32'(o_Data_Mem_Req), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t7_reset_drops_req", 32'({o_Data_Mem_Req, o_Data_Mem_Write, o_State}), 32'd0);
      repeat (2) @(negedge clk);
      chk("t7_instret", 32'(o_Instret), 32'd0);

      // T8: store with no load/store type is illegal
      dmr = 1'b1; op = OP_STORE; ls = LS_TYPE_NONE;
      #1;
      rst_n = 1'b1;
      expect_state("t8_fetch",  S_FETCH);
      expect_state("t8_decode", S_DECODE);
      expect_state("t8_trap",   S_TRAP);
      chk("t8_cause", 32'(o_Trap_Cause), 32'd1);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
